// File: rtl/sdith_commit_hash_if.sv
// Bus bundle for sdith_commit_hash: source RAM reads, hash-input RAM writes, hash control and
// digest stream. master = commitment engine, slave = RAMs and SHAKE block side.
interface sdith_commit_hash_if #(
  parameter string PARAMETER_SET = "L1"
);
  localparam int unsigned Lambda     = (PARAMETER_SET == "L5") ? 256 :
                                       (PARAMETER_SET == "L3") ? 192 : 128;
  localparam int unsigned SaltAw     = $clog2(2 * Lambda / 32);
  localparam int unsigned AuxAw      = $clog2(256 / 32);
  localparam int unsigned HashInSize = 8 + Lambda + 2 * Lambda + 32 + 256;
  localparam int unsigned HashAw     = $clog2(HashInSize / 32);
  localparam int unsigned CommitAw   = $clog2(2 * Lambda / 32);

  logic                start;
  logic                done;
  logic [31:0]         salt;
  logic [SaltAw-1:0]   salt_addr;
  logic                salt_rd;
  logic [31:0]         leaf_seed;
  logic [SaltAw-1:0]   leaf_seed_addr;
  logic                leaf_seed_rd;
  logic [15:0]         iteration;
  logic [15:0]         leaf_idx;
  logic [31:0]         aux;
  logic [AuxAw-1:0]    aux_addr;
  logic                aux_rd;
  logic [31:0]         hash_in;
  logic [HashAw-1:0]   hash_addr;
  logic                hash_wen;
  logic [31:0]         hash_data_out;
  logic                hash_data_out_valid;
  logic                hash_data_out_ready;
  logic [31:0]         hash_input_length_32;
  logic [31:0]         hash_input_length;
  logic [31:0]         hash_output_length;
  logic                hash_start;
  logic                hash_force_done;
  logic                hash_force_done_ack;
  logic [31:0]         commit;
  logic [CommitAw-1:0] commit_addr;
  logic                commit_valid;

  modport master (
    input  start, salt, leaf_seed, iteration, leaf_idx, aux,
    input  hash_data_out, hash_data_out_valid, hash_force_done_ack,
    output done, salt_addr, salt_rd, leaf_seed_addr, leaf_seed_rd, aux_addr, aux_rd,
    output hash_in, hash_addr, hash_wen, hash_data_out_ready,
    output hash_input_length_32, hash_input_length, hash_output_length,
    output hash_start, hash_force_done, commit, commit_addr, commit_valid
  );

  modport slave (
    output start, salt, leaf_seed, iteration, leaf_idx, aux,
    output hash_data_out, hash_data_out_valid, hash_force_done_ack,
    input  done, salt_addr, salt_rd, leaf_seed_addr, leaf_seed_rd, aux_addr, aux_rd,
    input  hash_in, hash_addr, hash_wen, hash_data_out_ready,
    input  hash_input_length_32, hash_input_length, hash_output_length,
    input  hash_start, hash_force_done, commit, commit_addr, commit_valid
  );
endinterface

// File: rtl/sdith_commit_hash.sv
// SDitH leaf commitment: packs prefix/salt/indices/seed/aux into the hash-input RAM, starts the
// SHAKE block, streams the digest out as commitment words and closes the hash handshake.
module sdith_commit_hash #(
  parameter string       PARAMETER_SET = "L1",
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned LAMBDA        = (PARAMETER_SET == "L5") ? 256 :
                                         (PARAMETER_SET == "L3") ? 192 : 128,
  parameter int unsigned M             = (PARAMETER_SET == "L5") ? 480 :
                                         (PARAMETER_SET == "L3") ? 352 : 230,
  parameter int unsigned SEED_SIZE     = LAMBDA,
  parameter int unsigned SALT_SIZE     = 2 * LAMBDA,
  parameter int unsigned RHO_SIZE      = LAMBDA / 8,
  parameter int unsigned AUX_SIZE      = 256,
  parameter int unsigned HASH_IN_SIZE  = 8 + SEED_SIZE + SALT_SIZE + 32 + AUX_SIZE
) (
  input logic                 clk,
  input logic                 rst_n,
  sdith_commit_hash_if.master bus
);
  localparam int unsigned HashInSize32 = ((HASH_IN_SIZE + 31) / 32) * 32;
  localparam int unsigned SaltWords    = SALT_SIZE / 32;
  localparam int unsigned SeedWords    = SEED_SIZE / 32;
  localparam int unsigned AuxWords     = AUX_SIZE / 32;
  localparam int unsigned CommitWords  = 2 * LAMBDA / 32;
  localparam int unsigned SaltAw       = $clog2(SaltWords);
  localparam int unsigned AuxAw        = $clog2(AuxWords);
  localparam int unsigned HashAw       = $clog2(HASH_IN_SIZE / 32);
  localparam int unsigned CommitAw     = $clog2(CommitWords);
  localparam int unsigned CntW         = $clog2(SaltWords + 1);

  if (DATA_WIDTH != 32 || M == 0 || RHO_SIZE == 0) begin : g_param_check
    $error("sdith_commit_hash: unsupported parameter set");
  end

  typedef enum logic [3:0] {
    StIdle, StLdSalt, StLdIdx, StLdSeed, StLdAux, StFlush, StStart, StRead, StForce, StDone
  } state_e;

  typedef enum logic [2:0] {SrcSalt, SrcIdx, SrcSeed, SrcAux, SrcFlush} src_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pend_q, pend_d;
  src_e              sel_q, sel_d;
  logic [7:0]        carry_q, carry_d;
  logic [HashAw-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]       hash_in_q, hash_in_d;
  logic [HashAw-1:0] hash_addr_q, hash_addr_d;
  logic              hash_wen_q, hash_wen_d;
  logic [31:0]       commit_q, commit_d;
  logic [CommitAw-1:0] commit_addr_q, commit_addr_d;
  logic              commit_valid_q, commit_valid_d;
  logic [31:0]       src_word;
  logic              hash_ready;
  logic              beat;

  assign hash_ready = (state_q == StRead);
  assign beat       = hash_ready && bus.hash_data_out_valid;

  // Control: read issue and phase sequencing; pend_q marks a source word arriving next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    sel_d   = sel_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLdSalt;
          cnt_d   = '0;
        end
      end
      StLdSalt: begin
        pend_d = 1'b1;
        sel_d  = SrcSalt;
        if (cnt_q == CntW'(SaltWords - 1)) begin
          cnt_d   = '0;
          state_d = StLdIdx;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLdIdx: begin
        pend_d  = 1'b1;
        sel_d   = SrcIdx;
        state_d = StLdSeed;
      end
      StLdSeed: begin
        pend_d = 1'b1;
        sel_d  = SrcSeed;
        if (cnt_q == CntW'(SeedWords - 1)) begin
          cnt_d   = '0;
          state_d = StLdAux;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLdAux: begin
        pend_d = 1'b1;
        sel_d  = SrcAux;
        if (cnt_q == CntW'(AuxWords - 1)) begin
          cnt_d   = '0;
          state_d = StFlush;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFlush: begin
        // Drain the last aux word, then push the leftover carry byte as a padded word.
        if (!pend_q) begin
          state_d = StStart;
        end else if (sel_q != SrcFlush) begin
          pend_d = 1'b1;
          sel_d  = SrcFlush;
        end
      end
      StStart: state_d = StRead;
      StRead: begin
        if (beat) begin
          if (cnt_q == CntW'(CommitWords - 1)) begin
            cnt_d   = '0;
            state_d = StForce;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StForce: begin
        if (bus.hash_force_done_ack) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Byte-alignment: each output word is the new source word shifted up by the one-byte prefix.
  always_comb begin
    src_word = '0;
    case (sel_q)
      SrcSalt:  src_word = bus.salt;
      SrcIdx:   src_word = {bus.leaf_idx, bus.iteration};
      SrcSeed:  src_word = bus.leaf_seed;
      SrcAux:   src_word = bus.aux;
      default:  src_word = '0;
    endcase

    carry_d     = carry_q;
    wr_ptr_d    = wr_ptr_q;
    hash_in_d   = hash_in_q;
    hash_addr_d = hash_addr_q;
    hash_wen_d  = 1'b0;
    if (state_q == StIdle) begin
      carry_d  = 8'h00;
      wr_ptr_d = '0;
    end else if (pend_q) begin
      hash_in_d   = {src_word[23:0], carry_q};
      carry_d     = src_word[31:24];
      hash_addr_d = wr_ptr_q;
      hash_wen_d  = 1'b1;
      wr_ptr_d    = wr_ptr_q + 1'b1;
    end

    commit_valid_d = beat;
    commit_d       = beat ? bus.hash_data_out : commit_q;
    commit_addr_d  = beat ? cnt_q[CommitAw-1:0] : commit_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      pend_q         <= 1'b0;
      sel_q          <= SrcSalt;
      carry_q        <= 8'h00;
      wr_ptr_q       <= '0;
      hash_in_q      <= '0;
      hash_addr_q    <= '0;
      hash_wen_q     <= 1'b0;
      commit_q       <= '0;
      commit_addr_q  <= '0;
      commit_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend_q         <= pend_d;
      sel_q          <= sel_d;
      carry_q        <= carry_d;
      wr_ptr_q       <= wr_ptr_d;
      hash_in_q      <= hash_in_d;
      hash_addr_q    <= hash_addr_d;
      hash_wen_q     <= hash_wen_d;
      commit_q       <= commit_d;
      commit_addr_q  <= commit_addr_d;
      commit_valid_q <= commit_valid_d;
    end
  end

  assign bus.salt_rd        = (state_q == StLdSalt);
  assign bus.salt_addr      = bus.salt_rd ? cnt_q[SaltAw-1:0] : '0;
  assign bus.leaf_seed_rd   = (state_q == StLdSeed);
  assign bus.leaf_seed_addr = bus.leaf_seed_rd ? cnt_q[SaltAw-1:0] : '0;
  assign bus.aux_rd         = (state_q == StLdAux);
  assign bus.aux_addr       = bus.aux_rd ? cnt_q[AuxAw-1:0] : '0;

  assign bus.hash_in   = hash_in_q;
  assign bus.hash_addr = hash_addr_q;
  assign bus.hash_wen  = hash_wen_q;

  assign bus.hash_input_length_32 = 32'(HashInSize32);
  assign bus.hash_input_length    = 32'(HASH_IN_SIZE);
  assign bus.hash_output_length   = 32'(2 * LAMBDA);

  assign bus.hash_start          = (state_q == StStart);
  assign bus.hash_data_out_ready = hash_ready;
  assign bus.hash_force_done     = (state_q == StForce);
  assign bus.done                = (state_q == StDone);

  assign bus.commit       = commit_q;
  assign bus.commit_addr  = commit_addr_q;
  assign bus.commit_valid = commit_valid_q;
endmodule

// File: tb/tb_sdith_commit_hash.sv
// Directed bench for sdith_commit_hash (L1): hand-computed hash-input words, digest stream with
// stalls, ignored start during READ and a mid-operation reset.
module tb_sdith_commit_hash;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdith_commit_hash_if #(.PARAMETER_SET("L1")) bus ();
  sdith_commit_hash #(.PARAMETER_SET("L1")) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    string       name;
    int          addr;
    logic [31:0] exp;
  } vec_t;

  logic [31:0] salt_mem [8];
  logic [31:0] seed_mem [8];
  logic [31:0] aux_mem  [8];
  logic [31:0] digest   [8];
  logic [31:0] hmem     [32];
  logic [31:0] run1_mem [22];
  logic [31:0] exp_words [22];

  int vecs = 0;
  int errs = 0;
  int wr_n, order_bad, hs_pulses, hs_cycle, last_wr, beats, commit_err;
  int force_cycles, done_pulses, post_done_act, timeout, total_cycles;

  always @(posedge clk) begin
    if (bus.salt_rd)      bus.salt      <= salt_mem[bus.salt_addr];
    if (bus.leaf_seed_rd) bus.leaf_seed <= seed_mem[bus.leaf_seed_addr];
    if (bus.aux_rd)       bus.aux       <= aux_mem[bus.aux_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_strobes"}, 32'({bus.salt_rd, bus.leaf_seed_rd, bus.aux_rd, bus.hash_wen,
                                  bus.hash_start, bus.hash_force_done, bus.hash_data_out_ready,
                                  bus.commit_valid, bus.done}), 32'h0);
    check({pfx, "_addrs"}, 32'({bus.salt_addr, bus.leaf_seed_addr, bus.aux_addr, bus.hash_addr,
                                bus.commit_addr}), 32'h0);
    check({pfx, "_hash_in"}, bus.hash_in, 32'h0);
    check({pfx, "_commit"}, bus.commit, 32'h0);
  endtask

  // One full commitment; the bench plays the SHAKE block and captures the hash-input RAM.
  task automatic run_op(input int stall_len, input bit poke_start);
    int cyc, d_idx, stall_cnt, done_cyc;
    bit poked;
    for (int i = 0; i < 32; i++) hmem[i] = 32'hDEAD_BEEF;
    wr_n = 0; order_bad = 0; hs_pulses = 0; hs_cycle = -1; last_wr = -1; beats = 0;
    commit_err = 0; force_cycles = 0; done_pulses = 0; post_done_act = 0; timeout = 0;
    d_idx = 0; stall_cnt = 0; poked = 1'b0; done_cyc = -1; cyc = 0;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    while (done_cyc < 0 || cyc <= done_cyc + 4) begin
      if (cyc >= 300) begin
        timeout = 1;
        break;
      end
      if (bus.hash_wen) begin
        if (bus.hash_addr != 5'(wr_n)) order_bad++;
        hmem[bus.hash_addr] = bus.hash_in;
        wr_n++;
        last_wr = cyc;
        if (done_cyc >= 0) post_done_act++;
      end
      if (done_cyc >= 0 && (bus.salt_rd || bus.hash_start)) post_done_act++;
      if (bus.hash_start) begin
        hs_pulses++;
        if (hs_cycle < 0) hs_cycle = cyc;
      end
      if (bus.commit_valid) begin
        if (beats >= 8) commit_err++;
        else if (bus.commit_addr != 3'(beats) || bus.commit != digest[beats]) commit_err++;
        beats++;
      end
      if (bus.hash_force_done) force_cycles++;
      if (bus.done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      bus.hash_force_done_ack = bus.hash_force_done && force_cycles == 3;
      bus.start = poke_start && !poked && bus.hash_data_out_ready && d_idx == 2;
      if (bus.start) poked = 1'b1;
      if (hs_cycle >= 0 && d_idx < 8) begin
        if (d_idx == 3 && stall_cnt < stall_len) begin
          bus.hash_data_out_valid = 1'b0;
          stall_cnt++;
        end else begin
          bus.hash_data_out_valid = 1'b1;
          bus.hash_data_out       = digest[d_idx];
        end
      end else begin
        bus.hash_data_out_valid = 1'b0;
      end
      if (bus.hash_data_out_valid && bus.hash_data_out_ready) d_idx++;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    bus.hash_data_out_valid = 1'b0;
    bus.hash_force_done_ack = 1'b0;
    total_cycles = cyc;
  endtask

  task automatic check_run(input string pfx);
    int bad = 0;
    check({pfx, "_timeout"}, 32'(timeout), 32'd0);
    check({pfx, "_write_count"}, 32'(wr_n), 32'd22);
    check({pfx, "_write_order"}, 32'(order_bad), 32'd0);
    for (int w = 0; w < 22; w++) if (hmem[w] !== exp_words[w]) bad++;
    check({pfx, "_stream_words_bad"}, 32'(bad), 32'd0);
    check({pfx, "_hash_start_pulses"}, 32'(hs_pulses), 32'd1);
    check({pfx, "_start_after_last_wr"}, 32'(hs_cycle > last_wr), 32'd1);
    check({pfx, "_start_latency_ok"}, 32'(hs_cycle >= 0 && hs_cycle <= 22 + 6), 32'd1);
    check({pfx, "_commit_beats"}, 32'(beats), 32'd8);
    check({pfx, "_commit_data_addr"}, 32'(commit_err), 32'd0);
    check({pfx, "_force_cycles"}, 32'(force_cycles), 32'd3);
    check({pfx, "_done_pulses"}, 32'(done_pulses), 32'd1);
    check({pfx, "_idle_after_done"}, 32'(post_done_act), 32'd0);
  endtask

  initial begin
    vec_t tbl [12];
    logic [7:0] bytes [88];
    int n;

    tbl[0]  = '{"word0_prefix",   0,  32'h0201_0000};
    tbl[1]  = '{"word1",          1,  32'h0605_0403};
    tbl[2]  = '{"word7",          7,  32'h1E1D_1C1B};
    tbl[3]  = '{"word8_indices",  8,  32'h2C00_3F1F};
    tbl[4]  = '{"word9_seed0",    9,  32'h2221_2000};
    tbl[5]  = '{"word10",         10, 32'h2625_2423};
    tbl[6]  = '{"word12",         12, 32'h2E2D_2C2B};
    tbl[7]  = '{"word13_aux0",    13, 32'h4241_402F};
    tbl[8]  = '{"word14",         14, 32'h4645_4443};
    tbl[9]  = '{"word20",         20, 32'h5E5D_5C5B};
    tbl[10] = '{"word21_pad",     21, 32'h0000_005F};
    tbl[11] = '{"word4",          4,  32'h1211_100F};

    for (int i = 0; i < 8; i++) begin
      salt_mem[i] = 32'h0302_0100 + 32'(i) * 32'h0404_0404;
      seed_mem[i] = 32'h2322_2120 + 32'(i) * 32'h0404_0404;
      aux_mem[i]  = 32'h4342_4140 + 32'(i) * 32'h0404_0404;
      digest[i]   = 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
    end

    // Independent byte-stream model of the packed hash input.
    for (int k = 0; k < 88; k++) bytes[k] = 8'h00;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++) bytes[1 + 4 * i + j] = salt_mem[i][8 * j +: 8];
    bytes[33] = 8'h3F; bytes[34] = 8'h00; bytes[35] = 8'h2C; bytes[36] = 8'h00;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) bytes[37 + 4 * i + j] = seed_mem[i][8 * j +: 8];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++) bytes[53 + 4 * i + j] = aux_mem[i][8 * j +: 8];
    for (int w = 0; w < 22; w++)
      exp_words[w] = {bytes[4 * w + 3], bytes[4 * w + 2], bytes[4 * w + 1], bytes[4 * w]};

    bus.start = 1'b0;
    bus.iteration = 16'd63;
    bus.leaf_idx = 16'd44;
    bus.hash_data_out = 32'h0;
    bus.hash_data_out_valid = 1'b0;
    bus.hash_force_done_ack = 1'b0;

    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("idle");
    check("input_length", bus.hash_input_length, 32'd680);
    check("input_length_32", bus.hash_input_length_32, 32'd704);
    check("output_length", bus.hash_output_length, 32'd256);

    // Run 1: plain commitment.
    run_op(0, 1'b0);
    check_run("run1");
    for (int i = 0; i < 12; i++) check(tbl[i].name, hmem[tbl[i].addr], tbl[i].exp);
    for (int w = 0; w < 22; w++) run1_mem[w] = hmem[w];
    $display("total cycles for one commitment: %0d", total_cycles);

    // Run 2: 5-cycle valid stall mid-digest plus a start pulse during READ.
    run_op(5, 1'b1);
    check_run("run2");
    n = 0;
    for (int w = 0; w < 22; w++) if (hmem[w] !== run1_mem[w]) n++;
    check("run2_same_as_run1", 32'(n), 32'd0);

    // Run 3: reset while seed words are being read.
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    n = 0;
    while (!bus.leaf_seed_rd && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("seed_phase_reached", 32'(bus.leaf_seed_rd), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_idle("midreset");
    @(negedge clk) rst_n = 1'b1;
    run_op(0, 1'b0);
    check_run("run3");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
